// File: rtl/round_key_xor_pipe.sv
// AddRoundKey stage: local round-key bank plus one registered valid/ready output slot.
// The selected key is XORed into the incoming state; a missing or out-of-range key passes the state through and flags out_err.
module round_key_xor_pipe #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned NUM_RK  = 15,
    parameter int unsigned RK_AW   = $clog2(NUM_RK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rk_wr_en,
    input  logic [RK_AW-1:0]   rk_wr_addr,
    input  logic [BLOCK_W-1:0] rk_wr_data,
    input  logic               rk_clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_state,
    input  logic [RK_AW-1:0]   in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_state,
    output logic [RK_AW-1:0]   out_round,
    output logic               out_err
);

    localparam int unsigned IDX_W = RK_AW + 1;

    logic [BLOCK_W-1:0] bank [NUM_RK];
    logic [NUM_RK-1:0]  rk_valid;

    logic               wr_in_range;
    logic               wr_hit;
    logic               rd_in_range;
    logic               key_hit;
    logic [BLOCK_W-1:0] key;
    logic               xfer;

    // Index range checks are widened by one bit so NUM_RK itself is representable.
    assign wr_in_range = {1'b0, rk_wr_addr} < IDX_W'(NUM_RK);
    assign rd_in_range = {1'b0, in_round} < IDX_W'(NUM_RK);
    assign wr_hit      = rk_wr_en && wr_in_range && !rst;

    // rst is included so the stage reports ready throughout reset.
    assign in_ready = rst || !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // Guarded read keeps an out-of-range index from ever selecting a non-existent entry.
    always_comb begin
        key     = '0;
        key_hit = 1'b0;
        if (rd_in_range) begin
            key     = bank[in_round];
            key_hit = rk_valid[in_round];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            bank[rk_wr_addr] <= rk_wr_data;
        end
    end

    // Clear first so a same-cycle write re-validates its own entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid <= '0;
        end else begin
            if (rk_clear) begin
                rk_valid <= '0;
            end
            if (wr_hit) begin
                rk_valid[rk_wr_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_err   <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_state <= key_hit ? (in_state ^ key) : in_state;
            out_round <= in_round;
            out_err   <= !key_hit;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_key_xor_pipe.sv
// Directed bench for round_key_xor_pipe configured as AES-128 (11 round keys).
module tb_round_key_xor_pipe;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned NUM_RK  = 11;
    localparam int unsigned RK_AW   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               rk_wr_en;
    logic [RK_AW-1:0]   rk_wr_addr;
    logic [BLOCK_W-1:0] rk_wr_data;
    logic               rk_clear;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_state;
    logic [RK_AW-1:0]   in_round;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_state;
    logic [RK_AW-1:0]   out_round;
    logic               out_err;

    int checks = 0;
    int errors = 0;

    round_key_xor_pipe #(
        .BLOCK_W(BLOCK_W),
        .NUM_RK (NUM_RK),
        .RK_AW  (RK_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rk_wr_en  (rk_wr_en),
        .rk_wr_addr(rk_wr_addr),
        .rk_wr_data(rk_wr_data),
        .rk_clear  (rk_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_round (out_round),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [BLOCK_W-1:0] key_of(int i);
        logic [7:0] b;
        b = 8'(i * 29 + 7);
        return {16{b}} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [BLOCK_W-1:0] st_of(int i);
        logic [31:0] w;
        w = 32'(i * 32'h9e3779b9 + 32'h1234);
        return {w, ~w, w ^ 32'h5a5a5a5a, w + 32'd1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input int addr, input logic [BLOCK_W-1:0] data);
        rk_wr_en   = 1'b1;
        rk_wr_addr = RK_AW'(addr);
        rk_wr_data = data;
        tick();
        rk_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_state !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", out_state); end
        checks++; if (out_round !== '0) begin errors++; $display("FAIL reset_round got %h exp 0", out_round); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = 128'h00112233445566778899aabbccddeeff;
        in_round  = '0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (out_state !== 128'h00102030405060708090a0b0c0d0e0f0) begin errors++; $display("FAIL basic_state got %h exp 00102030405060708090a0b0c0d0e0f0", out_state); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", out_err); end
        checks++; if (out_round !== 4'd0) begin errors++; $display("FAIL basic_round got %h exp 0", out_round); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 11; i++) write_key(i, key_of(i));
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_state = st_of(i);
            in_round = RK_AW'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin errors++; $display("FAIL b2b_valid[%0d] got v=%b e=%b exp v=1 e=0", i, out_valid, out_err); end
            checks++; if (out_state !== (st_of(i) ^ key_of(i))) begin errors++; $display("FAIL b2b_state[%0d] got %h exp %h", i, out_state, st_of(i) ^ key_of(i)); end
            checks++; if (out_round !== RK_AW'(i)) begin errors++; $display("FAIL b2b_round[%0d] got %0d exp %0d", i, out_round, i); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = st_of(20);
        in_round  = 4'd1;
        tick();
        in_state = st_of(21);
        in_round = 4'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_state !== (st_of(20) ^ key_of(1)) || out_round !== 4'd1) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b %h r=%0d exp v=1 %h r=1", c, out_valid, out_state, out_round, st_of(20) ^ key_of(1));
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_state !== (st_of(21) ^ key_of(2)) || out_round !== 4'd2) begin
            errors++; $display("FAIL bp_next got v=%b %h r=%0d exp v=1 %h r=2", out_valid, out_state, out_round, st_of(21) ^ key_of(2));
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
    endtask

    task automatic test_err();
        out_ready = 1'b1;
        rk_clear  = 1'b1;
        tick();
        rk_clear = 1'b0;
        in_valid = 1'b1;
        in_state = st_of(30);
        in_round = 4'd5;
        tick();
        checks++; if (out_state !== st_of(30) || out_err !== 1'b1 || out_round !== 4'd5) begin
            errors++; $display("FAIL err_cleared got %h e=%b r=%0d exp %h e=1 r=5", out_state, out_err, out_round, st_of(30));
        end
        in_state = st_of(31);
        in_round = 4'd11;
        tick();
        in_valid = 1'b0;
        checks++; if (out_state !== st_of(31) || out_err !== 1'b1 || out_round !== 4'd11) begin
            errors++; $display("FAIL err_range got %h e=%b r=%0d exp %h e=1 r=11", out_state, out_err, out_round, st_of(31));
        end
        // A write beyond the bank is dropped and must not alias onto a real entry.
        write_key(13, key_of(13));
        in_valid = 1'b1;
        in_state = st_of(32);
        in_round = 4'd2;
        tick();
        in_valid = 1'b0;
        checks++; if (out_state !== st_of(32) || out_err !== 1'b1) begin
            errors++; $display("FAIL err_oob_write got %h e=%b exp %h e=1", out_state, out_err, st_of(32));
        end
    endtask

    task automatic test_collision();
        out_ready = 1'b1;
        write_key(3, key_of(40));
        rk_wr_en   = 1'b1;
        rk_wr_addr = 4'd3;
        rk_wr_data = key_of(41);
        in_valid   = 1'b1;
        in_state   = st_of(42);
        in_round   = 4'd3;
        tick();
        rk_wr_en = 1'b0;
        checks++; if (out_state !== (st_of(42) ^ key_of(40)) || out_err !== 1'b0) begin
            errors++; $display("FAIL coll_old got %h e=%b exp %h e=0", out_state, out_err, st_of(42) ^ key_of(40));
        end
        in_state = st_of(43);
        tick();
        in_valid = 1'b0;
        checks++; if (out_state !== (st_of(43) ^ key_of(41)) || out_err !== 1'b0) begin
            errors++; $display("FAIL coll_new got %h e=%b exp %h e=0", out_state, out_err, st_of(43) ^ key_of(41));
        end
        // Clear with a simultaneous write: written entry survives, the rest are invalidated.
        rk_clear   = 1'b1;
        rk_wr_en   = 1'b1;
        rk_wr_addr = 4'd4;
        rk_wr_data = key_of(44);
        tick();
        rk_clear = 1'b0;
        rk_wr_en = 1'b0;
        in_valid = 1'b1;
        in_state = st_of(45);
        in_round = 4'd4;
        tick();
        checks++; if (out_state !== (st_of(45) ^ key_of(44)) || out_err !== 1'b0) begin
            errors++; $display("FAIL clr_wr_kept got %h e=%b exp %h e=0", out_state, out_err, st_of(45) ^ key_of(44));
        end
        in_round = 4'd3;
        tick();
        in_valid = 1'b0;
        checks++; if (out_state !== st_of(45) || out_err !== 1'b1) begin
            errors++; $display("FAIL clr_wr_other got %h e=%b exp %h e=1", out_state, out_err, st_of(45));
        end
    endtask

    task automatic test_reset_mid();
        write_key(0, key_of(50));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = st_of(51);
        in_round  = 4'd0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre got %b exp 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", in_ready); end
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL rm_out got v=%b e=%b exp v=0 e=0", out_valid, out_err); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = st_of(52);
        tick();
        in_valid = 1'b0;
        checks++; if (out_state !== st_of(52) || out_err !== 1'b1) begin
            errors++; $display("FAIL rm_bank_cleared got %h e=%b exp %h e=1", out_state, out_err, st_of(52));
        end
        write_key(0, key_of(53));
        in_valid = 1'b1;
        in_state = st_of(54);
        tick();
        in_valid = 1'b0;
        checks++; if (out_state !== (st_of(54) ^ key_of(53)) || out_err !== 1'b0) begin
            errors++; $display("FAIL rm_rewrite got %h e=%b exp %h e=0", out_state, out_err, st_of(54) ^ key_of(53));
        end
    endtask

    initial begin
        rst        = 1'b1;
        rk_wr_en   = 1'b0;
        rk_wr_addr = '0;
        rk_wr_data = '0;
        rk_clear   = 1'b0;
        in_valid   = 1'b0;
        in_state   = '0;
        in_round   = '0;
        out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_err();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_key_xor_pipe.md
# round_key_xor_pipe

Parametrised, registered AddRoundKey stage for the AES datapath. It holds a local round-key bank of `NUM_RK` entries, written by the key-schedule side. It XORs an incoming state with the entry selected by a per-transfer round index and presents the result behind a valid/ready handshake. It sits between the round logic (SubBytes/ShiftRows/MixColumns) and the next round register, and covers AES-128/192/256 through `NUM_RK`.

## Interface
Parameters:
- `BLOCK_W`, 128: state and round-key width in bits; must be a multiple of 8.
- `NUM_RK`, 15: number of round-key entries. Use 11, 13 or 15 for AES-128/192/256.
- `RK_AW`, `$clog2(NUM_RK)`: width of the round-key index.

Ports:
- `clk` input 1: sole clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rk_wr_en` input 1: write the round-key bank this cycle.
- `rk_wr_addr` input RK_AW: bank entry to write.
- `rk_wr_data` input BLOCK_W: round-key value.
- `rk_clear` input 1: invalidate all bank entries (synchronous).
- `in_valid` input 1: input transfer offered.
- `in_ready` output 1: stage can accept this cycle.
- `in_state` input BLOCK_W: state to be keyed.
- `in_round` input RK_AW: round-key index for this transfer.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer accepts this cycle.
- `out_state` output BLOCK_W: keyed state.
- `out_round` output RK_AW: round index carried with the result.
- `out_err` output 1: the key was unavailable and the state was passed through unmodified.

## Operation
- Bank: `NUM_RK` x `BLOCK_W` registers, plus one valid bit per entry.
  - A write with `rk_wr_en` and `rk_wr_addr < NUM_RK` stores the data and sets that entry's valid bit.
  - A write with an address `>= NUM_RK` is ignored.
- `rk_clear` clears all valid bits. Key data is not required to be zeroed.
  - If `rk_clear` and `rk_wr_en` occur in the same cycle, the write wins for its entry and all other entries are cleared.
- An input transfer occurs when `in_valid && in_ready`. On that edge the output register captures:
  - `out_state = in_state ^ bank[in_round]` if `in_round < NUM_RK` and that entry is valid. Otherwise `out_state = in_state` and `out_err = 1`.
  - `out_round = in_round`.
- Read/write collision: when a transfer and a bank write hit the same entry in the same cycle, the transfer uses the old contents and the old valid bit. The new value is visible from the next cycle.
- Handshake:
  - `in_ready = !out_valid || out_ready` (combinational). This gives full throughput, one transfer per cycle under continuous `out_ready`.
  - `out_valid` sets on a transfer. It clears when `out_ready` is high and no new transfer occurs.
  - While `out_valid && !out_ready`, `out_state`, `out_round` and `out_err` stay stable.
- `in_valid` is never required to wait for `in_ready`. The upstream must hold `in_state`/`in_round` until accepted.
- No state machine beyond the single output stage. The bank operates independently of the datapath.

## Timing
- Latency: 1 cycle from the input-transfer edge to `out_valid`. Throughput: 1 block per cycle.
- Reset (synchronous, on a `rst`-high edge): `out_valid=0`, `out_state=0`, `out_round=0`, `out_err=0`, all bank valid bits 0.
  - `in_ready` reads 1 during and after reset.
- Reset mid-operation discards a held result. Any transfer or write in the same cycle as `rst` is dropped.
- Bank writes take effect at the edge. Their data is usable by transfers one cycle later.
- Simultaneous output accept and new input: `out_valid` stays 1 and the new result replaces the old one on the same edge.
- Out-of-range `in_round` (`>= NUM_RK`, possible when `NUM_RK` is not a power of two) produces a pass-through with `out_err=1`. It never reads X.

## Test plan
1. Reset, write `bank[0] = 0x000102030405060708090a0b0c0d0e0f`, send `in_state = 0x00112233445566778899aabbccddeeff`, `in_round=0` → one cycle later `out_state = 0x00102030405060708090a0b0c0d0e0f0`, `out_err=0`, `out_round=0`.
2. Back-to-back stream of indices 0..10 with `out_ready=1` and `NUM_RK=11` → 11 results on 11 consecutive cycles, `in_ready` constantly 1, each result equal to `state ^ key[i]`.
3. Backpressure: hold `out_ready=0` for 3 cycles while `in_valid=1` → `in_ready=0`, `out_state` stable. On `out_ready=1` the held result is accepted and the next result appears on the following cycle, with no loss or duplication.
4. Unwritten entry 5 after `rk_clear`, and `in_round=11` with `NUM_RK=11` → `out_state = in_state`, `out_err=1` in both cases.
5. Collision: write `bank[3] = K2` and send a transfer with `in_round=3` in the same cycle, with old value `K1` → result `state ^ K1`. A transfer with `in_round=3` on the next cycle gives `state ^ K2`.
6. Assert `rst` while `out_valid=1` and `out_ready=0` → the next cycle shows `out_valid=0`, `out_err=0`, and a read of `bank[0]` returns `out_err=1` until it is rewritten.
